// File: rtl/fft_pkg.sv
// Shared FFT datapath constants, the 8-point twiddle table and the
// round-to-nearest / saturate helper used at the end of the multiplier.
package fft_pkg;

    localparam int DW      = 16;
    localparam int TWW     = 18;
    localparam int TW_FRAC = 16;
    localparam int TW_LAT  = 1;
    localparam int PW      = DW + TWW;
    localparam int ACC_W   = DW + TWW + 1;

    localparam logic signed [TWW-1:0]   TW_ONE   = 18'sd65536;
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(32'sd1 <<< (TW_FRAC - 1));
    localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'((32'sd1 <<< (DW - 1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0] ACC_MIN  = -ACC_W'(32'sd1 <<< (DW - 1));

    function automatic logic signed [TWW-1:0] w8_re(input logic [1:0] k);
        logic signed [TWW-1:0] v;
        case (k)
            2'd0:    v = 18'sd65536;
            2'd1:    v = 18'sd46341;
            2'd2:    v = 18'sd0;
            2'd3:    v = -18'sd46341;
            default: v = 18'sd0;
        endcase
        return v;
    endfunction

    function automatic logic signed [TWW-1:0] w8_im(input logic [1:0] k);
        logic signed [TWW-1:0] v;
        case (k)
            2'd0:    v = 18'sd0;
            2'd1:    v = -18'sd46341;
            2'd2:    v = -18'sd65536;
            2'd3:    v = -18'sd46341;
            default: v = 18'sd0;
        endcase
        return v;
    endfunction

    // Half-LSB bias then arithmetic shift gives round-half-up; integers
    // multiplied by exactly 1.0 come back unchanged.
    function automatic logic signed [DW-1:0] sat_round(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] t;
        logic signed [DW-1:0]    r;
        t = (x + RND_BIAS) >>> TW_FRAC;
        if (t > ACC_MAX) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else if (t < ACC_MIN) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = t[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Three-stage complex multiplier: (a + jb) * (c + jd), rounded and
// saturated back to data width. Valid/last ride alongside the data.
module cmult_pipe
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic signed [DW-1:0]  a,
    input  logic signed [DW-1:0]  b,
    input  logic signed [TWW-1:0] c,
    input  logic signed [TWW-1:0] d,
    output logic                  out_valid,
    output logic                  out_last,
    output logic signed [DW-1:0]  out_real,
    output logic signed [DW-1:0]  out_img
);

    logic signed [PW-1:0]    ac_r, bd_r, ad_r, bc_r;
    logic signed [ACC_W-1:0] re_r, im_r;
    logic                    v1_r, l1_r, v2_r, l2_r;

    // Stage 1: the four partial products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r <= 1'b0;
            l1_r <= 1'b0;
            ac_r <= '0;
            bd_r <= '0;
            ad_r <= '0;
            bc_r <= '0;
        end else begin
            v1_r <= in_valid;
            l1_r <= in_last;
            ac_r <= PW'(a) * PW'(c);
            bd_r <= PW'(b) * PW'(d);
            ad_r <= PW'(a) * PW'(d);
            bc_r <= PW'(b) * PW'(c);
        end
    end

    // Stage 2: combine into real and imaginary sums
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_r <= 1'b0;
            l2_r <= 1'b0;
            re_r <= '0;
            im_r <= '0;
        end else begin
            v2_r <= v1_r;
            l2_r <= l1_r;
            re_r <= ACC_W'(ac_r) - ACC_W'(bd_r);
            im_r <= ACC_W'(ad_r) + ACC_W'(bc_r);
        end
    end

    // Stage 3: round, saturate; data holds while no valid sample is present
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_img   <= '0;
        end else begin
            out_valid <= v2_r;
            out_last  <= v2_r & l2_r;
            if (v2_r) begin
                out_real <= sat_round(re_r);
                out_img  <= sat_round(im_r);
            end else begin
                out_real <= out_real;
                out_img  <= out_img;
            end
        end
    end

endmodule

// File: rtl/twiddle_rotator8.sv
// Twiddle-memory driver for an 8-point FFT stage: frames the sample
// stream, strobes S, aligns samples with returned twiddles and rotates them.
module twiddle_rotator8
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [DW-1:0]  in_real,
    input  logic signed [DW-1:0]  in_img,
    output logic                  S,
    input  logic signed [TWW-1:0] rotator_real,
    input  logic signed [TWW-1:0] rotator_img,
    output logic                  out_valid,
    output logic signed [DW-1:0]  out_real,
    output logic signed [DW-1:0]  out_img,
    output logic                  out_last,
    output logic                  frame_err
);

    logic [2:0]           cnt_r;
    logic                 frame_err_r;
    logic [TW_LAT-1:0]    vld_d_r;
    logic [TW_LAT-1:0]    last_d_r;
    logic signed [DW-1:0] re_d_r [TW_LAT];
    logic signed [DW-1:0] im_d_r [TW_LAT];
    logic                 last_s;

    // The memory steps through W8^k only for the upper half of the frame.
    assign S         = in_valid & cnt_r[2];
    assign last_s    = in_valid & (cnt_r == 3'd7);
    assign frame_err = frame_err_r;

    // Frame counter; a gap mid-frame aborts the frame and flags it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= 3'd0;
            frame_err_r <= 1'b0;
        end else if (in_valid) begin
            cnt_r       <= cnt_r + 3'd1;
            frame_err_r <= 1'b0;
        end else begin
            cnt_r       <= 3'd0;
            frame_err_r <= (cnt_r != 3'd0);
        end
    end

    // Alignment delay: hold each sample back until its twiddle arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_d_r  <= '0;
            last_d_r <= '0;
            for (int i = 0; i < TW_LAT; i++) begin
                re_d_r[i] <= '0;
                im_d_r[i] <= '0;
            end
        end else begin
            vld_d_r[0]  <= in_valid;
            last_d_r[0] <= last_s;
            re_d_r[0]   <= in_real;
            im_d_r[0]   <= in_img;
            for (int i = 1; i < TW_LAT; i++) begin
                vld_d_r[i]  <= vld_d_r[i-1];
                last_d_r[i] <= last_d_r[i-1];
                re_d_r[i]   <= re_d_r[i-1];
                im_d_r[i]   <= im_d_r[i-1];
            end
        end
    end

    cmult_pipe u_cmult (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_d_r[TW_LAT-1]),
        .in_last   (last_d_r[TW_LAT-1]),
        .a         (re_d_r[TW_LAT-1]),
        .b         (im_d_r[TW_LAT-1]),
        .c         (rotator_real),
        .d         (rotator_img),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_real  (out_real),
        .out_img   (out_img)
    );

endmodule

// File: tb/tb_twiddle_rotator8.sv
// Bench for twiddle_rotator8: models the twiddle memory, drives table and
// random frames, and checks outputs through an expected-value queue.
module tb_twiddle_rotator8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_real = 16'sd0;
    logic signed [15:0] in_img = 16'sd0;
    logic               S;
    logic signed [17:0] rotator_real;
    logic signed [17:0] rotator_img;
    logic               out_valid;
    logic signed [15:0] out_real;
    logic signed [15:0] out_img;
    logic               out_last;
    logic               frame_err;

    twiddle_rotator8 dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_real      (in_real),
        .in_img       (in_img),
        .S            (S),
        .rotator_real (rotator_real),
        .rotator_img  (rotator_img),
        .out_valid    (out_valid),
        .out_real     (out_real),
        .out_img      (out_img),
        .out_last     (out_last),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    localparam int TWR [4] = '{65536, 46341, 0, -46341};
    localparam int TWI [4] = '{0, -46341, -65536, -46341};

    // Twiddle memory: one cycle latency, steps W8^k while S is high
    logic [1:0] mem_k;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_k <= 2'd0;
            rotator_real <= 18'sd65536;
            rotator_img <= 18'sd0;
        end else if (S) begin
            rotator_real <= 18'(TWR[mem_k]);
            rotator_img <= 18'(TWI[mem_k]);
            mem_k <= mem_k + 2'd1;
        end else begin
            rotator_real <= 18'sd65536;
            rotator_img <= 18'sd0;
            mem_k <= 2'd0;
        end
    end

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               last;
    } exp_t;

    typedef struct {
        logic signed [15:0] in_re;
        logic signed [15:0] in_im;
        logic signed [15:0] ex_re;
        logic signed [15:0] ex_im;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    int   last_cnt = 0;
    logic [2:0] mcnt = 3'd0;
    logic signed [15:0] last_re = 16'sd0;
    logic signed [15:0] last_im = 16'sd0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] rnd_sat(input longint v);
        longint t;
        t = (v + 64'sd32768) >>> 16;
        if (t > 64'sd32767) return 16'sh7fff;
        if (t < -64'sd32768) return 16'sh8000;
        return 16'(t);
    endfunction

    // Output monitor: pops the scoreboard on every valid output
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (frame_err) err_cnt++;
            if (out_valid) begin
                if (out_last) last_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stale_valid: out_valid=1 with no sample pending at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_real", out_real, e.re);
                    chk("out_img", out_img, e.im);
                    chk("out_last", out_last, e.last);
                    last_re = e.re;
                    last_im = e.im;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic signed [15:0] re, input logic signed [15:0] im,
                         input logic use_exp, input logic signed [15:0] ere, input logic signed [15:0] eim);
        exp_t   e;
        longint tr, ti;
        logic   es;
        @(negedge clk);
        in_valid = v;
        in_real = re;
        in_img = im;
        es = v & mcnt[2];
        #1;
        chk("S", S, es);
        if (v) begin
            tr = mcnt[2] ? longint'(TWR[mcnt[1:0]]) : 64'sd65536;
            ti = mcnt[2] ? longint'(TWI[mcnt[1:0]]) : 64'sd0;
            e.re = use_exp ? ere : rnd_sat(longint'(re) * tr - longint'(im) * ti);
            e.im = use_exp ? eim : rnd_sat(longint'(re) * ti + longint'(im) * tr);
            e.last = (mcnt == 3'd7);
            sb.push_back(e);
            mcnt = mcnt + 3'd1;
        end else begin
            mcnt = 3'd0;
        end
    endtask

    task automatic drive_rand();
        drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, 16'sd0, 16'sd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, l0;
        vt[0]  = '{16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
        vt[1]  = '{16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
        vt[2]  = '{16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
        vt[3]  = '{16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
        vt[4]  = '{16'sd1000, 16'sd0, 16'sd1000, 16'sd0};
        vt[5]  = '{16'sd1000, 16'sd0, 16'sd707, -16'sd707};
        vt[6]  = '{16'sd1000, 16'sd0, 16'sd0, -16'sd1000};
        vt[7]  = '{16'sd1000, 16'sd0, -16'sd707, -16'sd707};
        vt[8]  = '{-16'sd1, 16'sd1, -16'sd1, 16'sd1};
        vt[9]  = '{16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768};
        vt[10] = '{-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767};
        vt[11] = '{16'sd12345, -16'sd321, 16'sd12345, -16'sd321};
        vt[12] = '{-16'sd5, 16'sd7, -16'sd5, 16'sd7};
        vt[13] = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd0};
        vt[14] = '{-16'sd32768, 16'sd0, 16'sd0, 16'sd32767};
        vt[15] = '{16'sd100, -16'sd100, -16'sd141, 16'sd0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_img", out_img, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_S", S, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Two contiguous table frames: (1000,0) rotation then extremes
        e0 = err_cnt;
        l0 = last_cnt;
        for (int i = 0; i < 16; i++)
            drive(1'b1, vt[i].in_re, vt[i].in_im, 1'b1, vt[i].ex_re, vt[i].ex_im);
        idle(1);
        drain();
        idle(3);
        chk("hold_real", out_real, last_re);
        chk("hold_img", out_img, last_im);
        chk("hold_valid", out_valid, 0);
        chk("table_err_count", err_cnt - e0, 0);
        chk("table_last_count", last_cnt - l0, 2);

        // Gap after sample 2: one error pulse, next sample restarts the frame
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) drive_rand();
        idle(1);
        for (int i = 0; i < 8; i++) drive_rand();
        idle(2);
        drain();
        chk("gap_err_count", err_cnt - e0, 1);

        // Three back-to-back random frames
        e0 = err_cnt;
        l0 = last_cnt;
        for (int i = 0; i < 24; i++) drive_rand();
        idle(1);
        drain();
        chk("b2b_err_count", err_cnt - e0, 0);
        chk("b2b_last_count", last_cnt - l0, 3);

        // Async reset with samples in flight
        for (int i = 0; i < 5; i++) drive_rand();
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_real", out_real, 0);
        chk("mid_rst_out_img", out_img, 0);
        chk("mid_rst_out_last", out_last, 0);
        sb.delete();
        mcnt = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(6);
        drive(1'b1, 16'sd4321, -16'sd1234, 1'b1, 16'sd4321, -16'sd1234);
        idle(1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_rotator8.md
Name: twiddle_rotator8

Overview:
- Consumer/driver end of the 8-point twiddle-memory interface.
- Accepts a streaming complex sample frame (8 samples).
- Drives the memory's S phase strobe, captures the returned rotator_real/rotator_img, and multiplies each sample by its twiddle.
- Sits between the radix-2 butterfly stage and the next FFT stage; output is rounded and saturated back to data width.

Parameters:
- DW, 16, signed data width per component (real/imag).
- TWW, 18, signed twiddle width, Q2.16 format (1.0 = 65536).
- TW_FRAC, 16, twiddle fractional bits; product right-shift amount.
- TW_LAT, 1, cycles from S/sample presentation to valid twiddle at memory output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  input sample valid
- in_real  in  DW  input real, signed
- in_img  in  DW  input imag, signed
- S  out  1  phase strobe to twiddle memory
- rotator_real  in  TWW  twiddle real from memory
- rotator_img  in  TWW  twiddle imag from memory
- out_valid  out  1  output sample valid
- out_real  out  DW  rotated real
- out_img  out  DW  rotated imag
- out_last  out  1  marks 8th sample of frame
- frame_err  out  1  one-cycle pulse on mid-frame gap

Behaviour:
- Reset (rst low, async): cnt=0, all pipeline valids=0, out_valid=0, out_real=out_img=0, out_last=0, frame_err=0. No output appears for pre-reset samples after release.
- Frame counter cnt (3 bit) advances on each accepted sample (in_valid=1), 7 wraps to 0.
- S is combinational: S = in_valid & cnt[2]. Samples 0..3 see S=0; samples 4..7 see S=1.
- Memory contract:
  - S=0 yields twiddle (65536, 0).
  - S=1 steps W8^k, k=0..3: (65536,0), (46341,-46341), (0,-65536), (-46341,-46341).
  - Twiddle is valid TW_LAT cycles after S.
- Data, valid and last are delayed TW_LAT cycles so they align with the twiddle.
- Multiplier pipeline (cmult_pipe), 3 registered stages:
  - Stage 1: four signed products ac, bd, ad, bc (DW+TWW bits).
  - Stage 2: re = ac - bd, im = ad + bc (DW+TWW+1 bits).
  - Stage 3: add 2^(TW_FRAC-1), arithmetic shift right TW_FRAC, saturate to [-2^(DW-1), 2^(DW-1)-1].
- Total latency in->out = TW_LAT + 3 = 4 cycles. Throughput 1 sample/cycle.
- Frames must be contiguous.
- If in_valid=0 while cnt!=0 (gap mid-frame):
  - frame_err pulses the next cycle.
  - cnt forces to 0 and S stays 0.
  - The next accepted sample starts a new frame.
  - Already-accepted samples drain normally.
- If in_valid=0 while cnt=0: idle, no error.
- out_last=1 with out_valid for the sample accepted at cnt=7.
- out_real/out_img hold their last value when out_valid=0.
- Exact pass-through: twiddle (65536,0) returns the input unchanged (no rounding bias for integers).

Decomposition:
- Shared package fft_pkg:
  - TW_FRAC, TW_ONE=65536, TWW, DW.
  - W8 constant table (used by the bench model).
  - Saturate/round function.
- Sub-module cmult_pipe (3-stage complex multiply, round, saturate) holds the arithmetic.
- Top level holds the counter, S generation, alignment delay, error logic and last tagging.

Test Plan:
- Reset then one contiguous frame, in=(1000,0) all 8 samples:
  - S = 0,0,0,0,1,1,1,1.
  - Outputs 4 cycles later: (1000,0)x5, (707,-707), (0,-1000), (-707,-707).
  - out_last on the 8th output.
- Saturation, in=(32767,32767) at cnt=5 (W8^1): out=(32767,0).
- Negative extreme, in=(-32768,0) at cnt=6: out=(0,32767) saturated, since +32768 clips.
- Gap: in_valid drops after sample 2 for 1 cycle.
  - frame_err pulses once.
  - Next sample sees S=0 and is treated as cnt=0.
  - 3 earlier outputs still emerge.
- Back-to-back 3 frames with random data: bit-exact against the fft_pkg model; out_last every 8 outputs; no frame_err.
- Async reset asserted mid-frame with samples in flight:
  - Outputs clear immediately and no stale out_valid appears.
  - First post-reset sample sees S=0.
